// File: rtl/addr_sweep_ctrl.sv
// addr_sweep_ctrl: paces one march element across the PMBIST address space.
// Drives the address_counter controls (s/r/hold/updwn) and op_valid/op_idx
// for the operation generator.
// Ports: clk/rst (sync, active-high); start_in/dir_in/nops_in/prmode_in
// sampled in IDLE; abort_in kills a sweep; s_out/r_out/hold_out/updwn_out
// to the counter; op_valid_out/op_idx_out pacing; busy_out/done_out status.
// Latency: LOAD one cycle after start, first op slot the cycle after that,
// and done_out N*nops cycles later. No backpressure: the sweep free-runs
// until completion or abort.
module addr_sweep_ctrl #(
    parameter int TASW = 8,
    parameter int OPW  = 3
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start_in,
    input  logic           dir_in,
    input  logic [OPW-1:0] nops_in,
    input  logic           prmode_in,
    input  logic           abort_in,
    output logic           s_out,
    output logic           r_out,
    output logic           hold_out,
    output logic           updwn_out,
    output logic           op_valid_out,
    output logic [OPW-1:0] op_idx_out,
    output logic           busy_out,
    output logic           done_out
);

    // Direction codes shared with address_counter.
    localparam logic ADDR_UP   = 1'b1;
    localparam logic ADDR_DOWN = 1'b0;

    // Linear sweeps visit 2^TASW addresses, LFSR sweeps skip the all-zero
    // state and visit one fewer.
    localparam logic [TASW-1:0] VISIT_LAST_LIN = {TASW{1'b1}};
    localparam logic [TASW-1:0] VISIT_LAST_PR  = {{(TASW-1){1'b1}}, 1'b0};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_OPS  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic            dir_q, dir_d;
    logic            prm_q, prm_d;
    logic [OPW-1:0]  nops_q, nops_d;
    logic [OPW-1:0]  op_cnt_q, op_cnt_d;
    logic [TASW-1:0] visit_q, visit_d;
    logic            updwn_q, updwn_d;

    logic            op_last;
    logic            last_addr;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            dir_q    <= ADDR_UP;
            prm_q    <= 1'b0;
            nops_q   <= '0;
            op_cnt_q <= '0;
            visit_q  <= '0;
            updwn_q  <= ADDR_UP;
        end else begin
            state_q  <= state_d;
            dir_q    <= dir_d;
            prm_q    <= prm_d;
            nops_q   <= nops_d;
            op_cnt_q <= op_cnt_d;
            visit_q  <= visit_d;
            updwn_q  <= updwn_d;
        end
    end

    // nops_q is never 0 once a sweep has started, so nops_q-1 cannot wrap
    // while in OPS.
    assign op_last   = (op_cnt_q == (nops_q - OPW'(1)));
    assign last_addr = prm_q ? (visit_q == VISIT_LAST_PR)
                             : (visit_q == VISIT_LAST_LIN);

    always_comb begin
        state_d      = state_q;
        dir_d        = dir_q;
        prm_d        = prm_q;
        nops_d       = nops_q;
        op_cnt_d     = op_cnt_q;
        visit_d      = visit_q;
        updwn_d      = updwn_q;

        s_out        = 1'b0;
        r_out        = 1'b0;
        hold_out     = 1'b1;
        updwn_out    = updwn_q;
        op_valid_out = 1'b0;
        op_idx_out   = '0;
        busy_out     = 1'b1;
        done_out     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                busy_out = 1'b0;
                if (start_in && !abort_in) begin
                    dir_d   = dir_in;
                    prm_d   = prmode_in;
                    nops_d  = (nops_in == '0) ? OPW'(1) : nops_in;
                    state_d = ST_LOAD;
                end
            end

            ST_LOAD: begin
                s_out     = (dir_q == ADDR_UP);
                r_out     = (dir_q == ADDR_DOWN);
                hold_out  = 1'b0;
                updwn_out = dir_q;
                // Remember the direction so IDLE/DONE keep driving it.
                updwn_d   = dir_q;
                op_cnt_d  = '0;
                visit_d   = '0;
                state_d   = ST_OPS;
            end

            ST_OPS: begin
                op_valid_out = 1'b1;
                op_idx_out   = op_cnt_q;
                updwn_out    = dir_q;
                // Release hold only on the final op of a non-final address so
                // the counter steps on the edge that closes that op slot.
                hold_out     = !(op_last && !last_addr);
                if (!op_last) begin
                    op_cnt_d = op_cnt_q + OPW'(1);
                end else if (!last_addr) begin
                    op_cnt_d = '0;
                    visit_d  = visit_q + TASW'(1);
                end else begin
                    state_d  = ST_DONE;
                end
            end

            ST_DONE: begin
                done_out = 1'b1;
                state_d  = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Abort beats every other transition; in IDLE it already blocks start.
        if (abort_in && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
        end
    end

endmodule

// File: tb/tb_addr_sweep_ctrl.sv
module tb_addr_sweep_ctrl;

    localparam int   TASW    = 8;
    localparam int   OPW     = 3;
    localparam int   AMAX    = (1 << TASW) - 1;
    localparam logic ADDR_UP = 1'b1;
    localparam logic ADDR_DN = 1'b0;

    logic           clk = 1'b0;
    logic           rst;
    logic           start_in;
    logic           dir_in;
    logic [OPW-1:0] nops_in;
    logic           prmode_in;
    logic           abort_in;
    logic           s_out;
    logic           r_out;
    logic           hold_out;
    logic           updwn_out;
    logic           op_valid_out;
    logic [OPW-1:0] op_idx_out;
    logic           busy_out;
    logic           done_out;

    always #5 clk = ~clk;

    addr_sweep_ctrl #(.TASW(TASW), .OPW(OPW)) dut (
        .clk          (clk),
        .rst          (rst),
        .start_in     (start_in),
        .dir_in       (dir_in),
        .nops_in      (nops_in),
        .prmode_in    (prmode_in),
        .abort_in     (abort_in),
        .s_out        (s_out),
        .r_out        (r_out),
        .hold_out     (hold_out),
        .updwn_out    (updwn_out),
        .op_valid_out (op_valid_out),
        .op_idx_out   (op_idx_out),
        .busy_out     (busy_out),
        .done_out     (done_out)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Per-sweep observations, filled in by sweep().
    int r_slots, r_done_j, r_done_cnt, r_hold0, r_s, r_r;
    int r_addr_err, r_idx_err, r_post_busy, r_abort_idle_err;

    // Start one sweep (start high in cycle 0) and watch it cycle by cycle.
    // A small address_counter model tracks the address the counter would show.
    task automatic sweep(input logic d, input int n, input logic p,
                         input int abort_slot, input bit extra_start);
        int m_addr, nops_eff, abort_j, exp_addr;
        m_addr = 0; abort_j = -1;
        nops_eff = (n == 0) ? 1 : n;
        r_slots = 0; r_done_j = -1; r_done_cnt = 0; r_hold0 = 0; r_s = 0; r_r = 0;
        r_addr_err = 0; r_idx_err = 0; r_post_busy = 0; r_abort_idle_err = 0;
        @(negedge clk);
        dir_in = d; nops_in = n[OPW-1:0]; prmode_in = p; start_in = 1'b1;
        for (int j = 1; j <= 3000; j++) begin
            @(negedge clk);
            start_in = 1'b0;
            abort_in = 1'b0;
            if (s_out) r_s++;
            if (r_out) r_r++;
            if (!hold_out) r_hold0++;
            if (abort_j > 0 && j == abort_j + 1) begin
                if (busy_out || !hold_out || op_valid_out) r_abort_idle_err++;
            end
            if (op_valid_out) begin
                if (int'(op_idx_out) != r_slots % nops_eff) r_idx_err++;
                if (!p) begin
                    exp_addr = (d == ADDR_UP) ? r_slots / nops_eff
                                              : AMAX - r_slots / nops_eff;
                    if (m_addr != exp_addr) r_addr_err++;
                end
                if (r_slots == abort_slot) begin
                    abort_in = 1'b1;
                    abort_j  = j;
                end
                if (extra_start && r_slots == 5) start_in = 1'b1;
                r_slots++;
            end
            if (done_out) begin
                r_done_cnt++;
                if (r_done_j < 0) r_done_j = j;
                if (extra_start) start_in = 1'b1;
            end
            if (r_done_j > 0 && j > r_done_j && busy_out) r_post_busy++;
            // Counter model: load, then step on each released hold.
            if (s_out)          m_addr = 0;
            else if (r_out)     m_addr = AMAX;
            else if (!hold_out) m_addr = (updwn_out == ADDR_UP) ? (m_addr + 1) & AMAX
                                                                : (m_addr - 1) & AMAX;
            if (r_done_j > 0 && j >= r_done_j + 3) break;
            if (abort_j > 0 && j >= abort_j + 20) break;
        end
        start_in = 1'b0;
        abort_in = 1'b0;
    endtask

    typedef struct {
        logic  dir;
        int    nops;
        logic  prm;
        int    exp_slots;
        int    exp_done;
        int    exp_hold0;
    } vec_t;

    vec_t vecs[5];

    initial begin
        vecs[0] = '{ADDR_UP, 1, 1'b0,  256,  258, 256};
        vecs[1] = '{ADDR_DN, 3, 1'b0,  768,  770, 256};
        vecs[2] = '{ADDR_UP, 0, 1'b0,  256,  258, 256};
        vecs[3] = '{ADDR_UP, 2, 1'b1,  510,  512, 255};
        vecs[4] = '{ADDR_DN, 5, 1'b1, 1275, 1277, 255};

        rst = 1'b1; start_in = 1'b0; dir_in = ADDR_DN; nops_in = '0;
        prmode_in = 1'b0; abort_in = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_hold",   int'(hold_out),     1);
        chk("rst_updwn",  int'(updwn_out),    int'(ADDR_UP));
        chk("rst_s",      int'(s_out),        0);
        chk("rst_r",      int'(r_out),        0);
        chk("rst_valid",  int'(op_valid_out), 0);
        chk("rst_busy",   int'(busy_out),     0);
        chk("rst_done",   int'(done_out),     0);
        chk("rst_idx",    int'(op_idx_out),   0);
        rst = 1'b0;

        for (int i = 0; i < 5; i++) begin
            sweep(vecs[i].dir, vecs[i].nops, vecs[i].prm, -1, 1'b0);
            chk($sformatf("v%0d_slots", i),    r_slots,    vecs[i].exp_slots);
            chk($sformatf("v%0d_done_at", i),  r_done_j,   vecs[i].exp_done);
            chk($sformatf("v%0d_done_cnt", i), r_done_cnt, 1);
            chk($sformatf("v%0d_hold0", i),    r_hold0,    vecs[i].exp_hold0);
            chk($sformatf("v%0d_s", i),        r_s,        (vecs[i].dir == ADDR_UP) ? 1 : 0);
            chk($sformatf("v%0d_r", i),        r_r,        (vecs[i].dir == ADDR_UP) ? 0 : 1);
            chk($sformatf("v%0d_addr_err", i), r_addr_err, 0);
            chk($sformatf("v%0d_idx_err", i),  r_idx_err,  0);
            chk($sformatf("v%0d_post_busy", i), r_post_busy, 0);
        end

        // After a DOWN sweep the idle direction stays DOWN.
        chk("idle_updwn_hold", int'(updwn_out), int'(ADDR_DN));

        // Abort during op slot 100, then a normal sweep must follow.
        sweep(ADDR_UP, 1, 1'b0, 100, 1'b0);
        chk("abort_slots",     r_slots,          101);
        chk("abort_no_done",   r_done_cnt,       0);
        chk("abort_idle",      r_abort_idle_err, 0);
        chk("abort_addr_err",  r_addr_err,       0);
        sweep(ADDR_UP, 2, 1'b0, -1, 1'b0);
        chk("after_abort_slots", r_slots,  512);
        chk("after_abort_done",  r_done_j, 514);

        // start_in pulsed during OPS and during DONE is ignored.
        sweep(ADDR_DN, 1, 1'b0, -1, 1'b1);
        chk("xstart_slots",     r_slots,     256);
        chk("xstart_done_at",   r_done_j,    258);
        chk("xstart_done_cnt",  r_done_cnt,  1);
        chk("xstart_post_busy", r_post_busy, 0);

        // start together with abort in IDLE does not launch.
        @(negedge clk);
        start_in = 1'b1; abort_in = 1'b1;
        @(negedge clk);
        start_in = 1'b0; abort_in = 1'b0;
        chk("start_abort_busy", int'(busy_out), 0);
        @(negedge clk);
        chk("start_abort_s",    int'(s_out | r_out), 0);

        // Synchronous reset mid-sweep behaves like abort.
        @(negedge clk);
        dir_in = ADDR_UP; nops_in = 3'd1; prmode_in = 1'b0; start_in = 1'b1;
        @(negedge clk);
        start_in = 1'b0;
        repeat (10) @(negedge clk);
        chk("mid_busy", int'(busy_out), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_busy",  int'(busy_out),     0);
        chk("rst_mid_hold",  int'(hold_out),     1);
        chk("rst_mid_valid", int'(op_valid_out), 0);
        repeat (3) @(negedge clk);
        chk("rst_mid_no_done", int'(done_out), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/addr_sweep_ctrl.md
# addr_sweep_ctrl

Sequencing controller that drives the PMBIST address counter's `s_in`, `r_in`, `hold_in` and `updwn_in` controls for one march element. It loads the counter with the first or last address and holds each address for a programmable number of read/write operations. It advances the counter between addresses and flags completion after the full address space has been visited. It sits between the march-element decoder and `address_counter`, and paces the operation generator through `op_valid_out` / `op_idx_out`.

## Interface
- `TASW`, default `ADDR_WIDTH` (8): address width; sweep length is 2^TASW addresses.
- `OPW`, default 3: width of the per-address operation count and index.
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `start_in`  in  1  single-cycle request to begin a sweep; ignored unless in IDLE.
- `dir_in`  in  1  sweep direction, sampled with `start_in`: `ADDR_UP` or `ADDR_DOWN` (defines.v codes).
- `nops_in`  in  OPW  operations per address, sampled with `start_in`; value 0 is treated as 1.
- `prmode_in`  in  1  sampled with `start_in`; 1 = pseudo-random (LFSR) sweep of 2^TASW-1 addresses.
- `abort_in`  in  1  terminates the sweep immediately without a done pulse.
- `s_out`  out  1  to counter `s_in`: load first address.
- `r_out`  out  1  to counter `r_in`: load last address.
- `hold_out`  out  1  to counter `hold_in`.
- `updwn_out`  out  1  to counter `updwn_in`.
- `op_valid_out`  out  1  current cycle is an operation slot at a stable address.
- `op_idx_out`  out  OPW  index of the operation within the current address, 0..nops-1.
- `busy_out`  out  1  high in every state except IDLE.
- `done_out`  out  1  one-cycle pulse when the sweep completes.

## Operation
- Moore FSM with states IDLE, LOAD, OPS and DONE. All outputs decode from registered state and registers.
- Internal registers:
  - latched `dir`, `nops` (0 mapped to 1) and `prm`.
  - `op_cnt` [OPW-1:0].
  - `visit` [TASW-1:0], which counts completed addresses.
- Last-address condition `last_addr`: `visit == 2^TASW-1` when prm=0, and `visit == 2^TASW-2` when prm=1.
- **IDLE:** `hold_out`=1, `s_out`=`r_out`=0, `op_valid_out`=0. On `start_in`=1 and `abort_in`=0, latch the inputs and go to LOAD.
- **LOAD (1 cycle):**
  - `s_out`=1 if dir=`ADDR_UP`, otherwise `r_out`=1.
  - `updwn_out`=dir and `hold_out`=0.
  - Clear `op_cnt` and `visit`, then go to OPS.
- **OPS:**
  - `op_valid_out`=1, `op_idx_out`=`op_cnt`, `updwn_out`=dir.
  - `hold_out` = NOT(`op_cnt`==nops-1 AND NOT `last_addr`). The counter therefore advances on the edge that ends the final op of each address, and the address is stable for every op slot.
  - When `op_cnt`≠nops-1: increment `op_cnt`.
  - When `op_cnt`==nops-1 and not `last_addr`: clear `op_cnt`, increment `visit`, stay in OPS.
  - When `op_cnt`==nops-1 and `last_addr`: go to DONE.
- **DONE (1 cycle):** `done_out`=1, `hold_out`=1, then go to IDLE. A `start_in` during DONE is ignored.
- **Abort:** `abort_in`=1 in LOAD, OPS or DONE forces IDLE on the next edge. No `done_out` is produced and `hold_out` returns to 1. `abort_in` has priority over every other transition. `abort_in` together with `start_in` in IDLE stays in IDLE.
- `updwn_out` holds its last driven value in IDLE and DONE.

## Timing
- Reset state and output values:
  - state IDLE.
  - `hold_out`=1, `updwn_out`=`ADDR_UP`.
  - `s_out`, `r_out`, `op_valid_out`, `busy_out`, `done_out` = 0.
  - `op_idx_out`=0, and all internal counters = 0.
  - `rst` mid-sweep overrides `abort_in` and behaves identically to abort.
- `start_in` sampled at edge k:
  - LOAD occupies cycle k+1, and the counter loads at edge k+2.
  - The first `op_valid_out` is in cycle k+2, with the first address on `tas_out`.
- Sweep length is 1 + N·nops + 1 cycles, where N = 2^TASW (prm=0) or 2^TASW-1 (prm=1).
  - `done_out` occurs in cycle k+2+N·nops.
- Back-to-back sweeps: the earliest accepted `start_in` is in the cycle after DONE, i.e. in IDLE.

## Test plan
- nops=1, dir=UP, prm=0, TASW=8, with `address_counter` in LIUD mode:
  - 256 consecutive `op_valid_out` cycles with `tas_out` 0x00..0xFF.
  - `done_out` exactly 258 cycles after `start_in`.
  - `hold_out` is 0 only on the LOAD cycle and on op cycles 0..254.
- nops=3, dir=DOWN:
  - `r_out` pulses once.
  - Each address 0xFF..0x00 is held for `op_idx_out` 0, 1, 2.
  - 768 op slots, and `done_out` at start+770.
- nops=0: behaves exactly as nops=1, with 256 slots and `op_idx_out` always 0.
- prm=1, PRUD seed, nops=2:
  - 255 distinct addresses, none repeated.
  - 510 op slots, and `done_out` at start+512.
- `abort_in` asserted during op slot 100:
  - IDLE next cycle, with `busy_out`=0 and `hold_out`=1.
  - No `done_out` pulse.
  - A new `start_in` is then accepted normally.
- `start_in` pulsed during OPS and during DONE: ignored, the sweep length is unchanged, and only one `done_out` pulse occurs.
